mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_rr_arb2.sv | 18 +
 rtl/mem_port_arbiter.sv | 91 +++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester block-RAM port arbiter:
// requester-ID encoding and default bus widths.
package mem_port_arbiter_pkg;

  typedef enum logic {
    REQ_R0 = 1'b0,
    REQ_R1 = 1'b1
  } req_id_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester that was not granted most recently.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_e    last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = (last_grant_i == REQ_R1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two single-beat requesters onto one port of a 1-cycle-latency
// block RAM. Handshake: a transaction completes on a rising edge where both
// rN_req_valid and rN_req_ready are high; ready never rises without valid.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                r0_req_valid,
  output logic                r0_req_ready,
  input  logic [ADDR_W-1:0]   r0_req_addr,
  input  logic [DATA_W/8-1:0] r0_req_we,
  input  logic [DATA_W-1:0]   r0_req_wdata,
  output logic                r0_rsp_valid,
  input  logic                r1_req_valid,
  output logic                r1_req_ready,
  input  logic [ADDR_W-1:0]   r1_req_addr,
  input  logic [DATA_W/8-1:0] r1_req_we,
  input  logic [DATA_W-1:0]   r1_req_wdata,
  output logic                r1_rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout
);

  logic [1:0] req;
  logic [1:0] gnt;
  req_id_e    last_grant_q, last_grant_d;
  logic       rsp_valid_q, rsp_valid_d;
  req_id_e    rsp_id_q, rsp_id_d;
  logic       unused_low_addr;

  // Byte offsets are dropped; alignment belongs to the requester.
  assign unused_low_addr = ^{r0_req_addr[1:0], r1_req_addr[1:0]};

  assign req = rst ? 2'b00 : {r1_req_valid, r0_req_valid};

  rr_arb2 u_rr_arb2 (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  always_comb begin
    r0_req_ready = gnt[0];
    r1_req_ready = gnt[1];
    mem_en       = |gnt;
    mem_we       = '0;
    mem_addr     = '0;
    mem_din      = '0;
    last_grant_d = last_grant_q;
    rsp_valid_d  = |gnt;
    rsp_id_d     = REQ_R0;
    if (gnt[1]) begin
      mem_we       = r1_req_we;
      mem_addr     = {2'b00, r1_req_addr[ADDR_W-1:2]};
      mem_din      = r1_req_wdata;
      last_grant_d = REQ_R1;
      rsp_id_d     = REQ_R1;
    end else if (gnt[0]) begin
      mem_we       = r0_req_we;
      mem_addr     = {2'b00, r0_req_addr[ADDR_W-1:2]};
      mem_din      = r0_req_wdata;
      last_grant_d = REQ_R0;
    end
  end

  // A response pending across the edge into reset is masked, not delivered.
  assign r0_rsp_valid = rsp_valid_q && (rsp_id_q == REQ_R0) && !rst;
  assign r1_rsp_valid = rsp_valid_q && (rsp_id_q == REQ_R1) && !rst;
  assign rsp_rdata    = mem_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_R1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= REQ_R0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, then randomized traffic
// checked against a transaction-level model with its own word memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req_valid, r1_req_valid;
  logic        r0_req_ready, r1_req_ready;
  logic [31:0] r0_req_addr, r1_req_addr;
  logic [3:0]  r0_req_we, r1_req_we;
  logic [31:0] r0_req_wdata, r1_req_wdata;
  logic        r0_rsp_valid, r1_rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_din;
  logic [31:0] mem_dout = '0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
    .r0_req_addr(r0_req_addr), .r0_req_we(r0_req_we),
    .r0_req_wdata(r0_req_wdata), .r0_rsp_valid(r0_rsp_valid),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
    .r1_req_addr(r1_req_addr), .r1_req_we(r1_req_we),
    .r1_req_wdata(r1_req_wdata), .r1_rsp_valid(r1_rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- block RAM (read-first, 1-cycle latency) ----------------
  logic [31:0] bram [0:255];
  logic        init_mem;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    if (i == 2) return 32'hFFFF_FFFF;
    return 32'hA000_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr[7:0]][8*b +: 8] <= mem_din[8*b +: 8];
      mem_dout <= bram[mem_addr[7:0]];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] gold [0:255];
  logic [33:0] exp_q[$];   // {id, is_read, read data}
  int          last_w;     // most recent winner, 1 after reset
  int          cur_g;      // winner in the cycle just finished, -1 if none

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // One cycle: inputs already driven just after a negedge.
  task automatic cycle();
    int          g;
    int          w;
    logic [31:0] a, d;
    logic [3:0]  we;
    logic [33:0] e;
    #1;
    g = -1;
    if (!rst) begin
      if (r0_req_valid && r1_req_valid) g = (last_w == 1) ? 0 : 1;
      else if (r0_req_valid) g = 0;
      else if (r1_req_valid) g = 1;
    end
    chk("r0_req_ready", {31'b0, r0_req_ready}, {31'b0, g == 0});
    chk("r1_req_ready", {31'b0, r1_req_ready}, {31'b0, g == 1});
    chk("mem_en", {31'b0, mem_en}, {31'b0, g >= 0});
    if (g >= 0) begin
      a  = (g == 0) ? r0_req_addr  : r1_req_addr;
      we = (g == 0) ? r0_req_we    : r1_req_we;
      d  = (g == 0) ? r0_req_wdata : r1_req_wdata;
      chk("mem_addr", mem_addr, a / 4);
      chk("mem_we", {28'b0, mem_we}, {28'b0, we});
      chk("mem_din", mem_din, d);
    end else begin
      chk("mem_we_idle", {28'b0, mem_we}, 32'h0);
    end
    if (rst) exp_q.delete();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("r0_rsp_valid", {31'b0, r0_rsp_valid}, {31'b0, e[33] == 1'b0});
      chk("r1_rsp_valid", {31'b0, r1_rsp_valid}, {31'b0, e[33] == 1'b1});
      if (e[32]) chk("rsp_rdata", rsp_rdata, e[31:0]);
    end else begin
      chk("r0_rsp_idle", {31'b0, r0_rsp_valid}, 32'h0);
      chk("r1_rsp_idle", {31'b0, r1_rsp_valid}, 32'h0);
    end
    if (g >= 0) begin
      w = int'(a[9:2]);
      if (we == 4'b0) begin
        exp_q.push_back({g[0], 1'b1, gold[w]});
      end else begin
        for (int b = 0; b < 4; b++) if (we[b]) gold[w][8*b +: 8] = d[8*b +: 8];
        exp_q.push_back({g[0], 1'b0, 32'h0});
      end
      last_w = g;
    end
    if (rst) last_w = 1;
    cur_g = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, v0, v1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [3:0]  we1;
    logic [31:0] wd1;
    logic        e_rdy0, e_rdy1, e_en;
    logic [31:0] e_maddr;
    logic        e_rsp0, e_rsp1, e_chk_rd;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(
    input logic r, v0, v1, input logic [31:0] a0, a1, input logic [3:0] we1,
    input logic [31:0] wd1, input logic rdy0, rdy1, en, input logic [31:0] maddr,
    input logic rsp0, rsp1, chk_rd, input logic [31:0] rdata);
    vec_t t;
    t.rst = r; t.v0 = v0; t.v1 = v1; t.a0 = a0; t.a1 = a1; t.we1 = we1; t.wd1 = wd1;
    t.e_rdy0 = rdy0; t.e_rdy1 = rdy1; t.e_en = en; t.e_maddr = maddr;
    t.e_rsp0 = rsp0; t.e_rsp1 = rsp1; t.e_chk_rd = chk_rd; t.e_rdata = rdata;
    return t;
  endfunction

  task automatic rnd_req(output logic v, output logic [31:0] a,
                         output logic [3:0] we, output logic [31:0] d);
    v  = ($urandom_range(0, 99) < 70);
    a  = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
    we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
    d  = $urandom;
  endtask

  vec_t tv [0:20];

  initial begin
    // reset with both valid high
    tv[0]  = mk(1, 1, 1, 32'h10, 32'h8, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[1]  = tv[0];
    tv[2]  = tv[0];
    // lone read of word 4
    tv[3]  = mk(0, 1, 0, 32'h10, 32'h8, 4'h0, 0, 1, 0, 1, 32'h4, 0, 0, 0, 0);
    tv[4]  = mk(0, 0, 0, 32'h10, 32'h8, 4'h0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hDEAD_BEEF);
    tv[5]  = mk(1, 0, 0, 32'h10, 32'h8, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // sustained contention after reset
    tv[6]  = mk(0, 1, 1, 32'h0, 32'h4, 4'h0, 0, 1, 0, 1, 32'h0, 0, 0, 0, 0);
    tv[7]  = mk(0, 1, 1, 32'h0, 32'h4, 4'h0, 0, 0, 1, 1, 32'h1, 1, 0, 1, 32'hA000_0000);
    tv[8]  = mk(0, 1, 1, 32'h0, 32'h4, 4'h0, 0, 1, 0, 1, 32'h0, 0, 1, 1, 32'hA000_0001);
    tv[9]  = mk(0, 1, 1, 32'h0, 32'h4, 4'h0, 0, 0, 1, 1, 32'h1, 1, 0, 1, 32'hA000_0000);
    tv[10] = mk(0, 0, 0, 32'h0, 32'h4, 4'h0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA000_0001);
    // partial write then read-back
    tv[11] = mk(0, 0, 1, 32'h10, 32'h8, 4'h3, 32'h1234_5678, 0, 1, 1, 32'h2, 0, 0, 0, 0);
    tv[12] = mk(0, 0, 1, 32'h10, 32'h8, 4'h0, 0, 0, 1, 1, 32'h2, 0, 1, 0, 0);
    tv[13] = mk(0, 0, 0, 32'h10, 32'h8, 4'h0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFF_5678);
    // reset right after a handshake
    tv[14] = mk(0, 1, 0, 32'h10, 32'h8, 4'h0, 0, 1, 0, 1, 32'h4, 0, 0, 0, 0);
    tv[15] = mk(1, 1, 1, 32'h10, 32'h8, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[16] = mk(0, 1, 1, 32'h10, 32'h8, 4'h0, 0, 1, 0, 1, 32'h4, 0, 0, 0, 0);
    // withdrawal of r1 while r0 holds the grant
    tv[17] = mk(0, 0, 1, 32'h10, 32'h8, 4'h0, 0, 0, 1, 1, 32'h2, 1, 0, 1, 32'hDEAD_BEEF);
    tv[18] = mk(0, 1, 1, 32'h10, 32'h8, 4'h0, 0, 1, 0, 1, 32'h4, 0, 1, 1, 32'hFFFF_5678);
    tv[19] = mk(0, 0, 0, 32'h10, 32'h8, 4'h0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hDEAD_BEEF);
    tv[20] = mk(0, 0, 0, 32'h10, 32'h8, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 256; i++) gold[i] = init_word(i);
    last_w = 1;
    cur_g  = -1;
    rst = 1'b1; init_mem = 1'b1;
    r0_req_valid = 0; r0_req_addr = 0; r0_req_we = 0; r0_req_wdata = 0;
    r1_req_valid = 0; r1_req_addr = 0; r1_req_we = 0; r1_req_wdata = 0;
    @(negedge clk);
    init_mem = 1'b0;

    for (int i = 0; i <= 20; i++) begin
      rst = tv[i].rst;
      r0_req_valid = tv[i].v0; r0_req_addr = tv[i].a0; r0_req_we = 4'h0; r0_req_wdata = 32'h0;
      r1_req_valid = tv[i].v1; r1_req_addr = tv[i].a1;
      r1_req_we = tv[i].we1; r1_req_wdata = tv[i].wd1;
      #1;
      chk($sformatf("row%0d rdy0", i), {31'b0, r0_req_ready}, {31'b0, tv[i].e_rdy0});
      chk($sformatf("row%0d rdy1", i), {31'b0, r1_req_ready}, {31'b0, tv[i].e_rdy1});
      chk($sformatf("row%0d en", i), {31'b0, mem_en}, {31'b0, tv[i].e_en});
      if (tv[i].e_en) chk($sformatf("row%0d maddr", i), mem_addr, tv[i].e_maddr);
      chk($sformatf("row%0d rsp0", i), {31'b0, r0_rsp_valid}, {31'b0, tv[i].e_rsp0});
      chk($sformatf("row%0d rsp1", i), {31'b0, r1_rsp_valid}, {31'b0, tv[i].e_rsp1});
      if (tv[i].e_chk_rd) chk($sformatf("row%0d rdata", i), rsp_rdata, tv[i].e_rdata);
      cycle();
    end

    // randomized traffic: waiting requests hold fields, sometimes withdraw
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (r0_req_valid && cur_g != 0) begin
        if ($urandom_range(0, 9) == 0) r0_req_valid = 1'b0;
      end else begin
        rnd_req(r0_req_valid, r0_req_addr, r0_req_we, r0_req_wdata);
      end
      if (r1_req_valid && cur_g != 1) begin
        if ($urandom_range(0, 9) == 0) r1_req_valid = 1'b0;
      end else begin
        rnd_req(r1_req_valid, r1_req_addr, r1_req_we, r1_req_wdata);
      end
      cycle();
    end

    rst = 1'b0; r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
